// File: rtl/jtframe_prog_pack.sv
// Download packer: queues HPS ioctl bytes in a small FIFO and issues them as SDRAM programming writes.
// Optional checksum of accepted bytes is enabled by defining JTFRAME_DWNLD_CHKSUM_EN.
module jtframe_prog_pack #(
    parameter int DEPTH = 4,
    parameter bit SWAB  = 1'b0
) (
    input  logic        clk_rom,
    input  logic        rst,
    input  logic        downloading,
    input  logic [22:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    input  logic        prog_rdy,
    output logic [21:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic [1:0]  prog_mask,
    output logic        prog_we,
    output logic        prog_rd,
    output logic        dwnld_busy,
    output logic        overflow,
    output logic [15:0] chksum
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WR, GAP} state_t;

    state_t      state_reg, state_next;
    logic [30:0] fifo_mem [DEPTH];
    logic [AW:0] wr_ptr_reg, rd_ptr_reg;
    logic        dl_reg, busy_reg, ovf_reg;
    logic        push, pop, full, empty, accept, drop, dl_rise, issue;
    logic        lane;

    // Extra wrap bit on the pointers tells full from empty.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign push    = ioctl_wr & downloading;
    assign pop     = (state_reg == WR) & prog_rdy;
    assign accept  = push & (~full | pop);
    assign drop    = push & full & ~pop;
    assign dl_rise = downloading & ~dl_reg;
    assign issue   = (state_reg == IDLE) & ~empty;
    assign lane    = fifo_mem[rd_ptr_reg[AW-1:0]][8] ^ SWAB;

    assign prog_rd    = 1'b0;
    assign dwnld_busy = busy_reg;
    assign overflow   = ovf_reg;

    always_ff @(posedge clk_rom) begin
        if (accept) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= {ioctl_addr, ioctl_data};
        end
    end

    always_ff @(posedge clk_rom) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            state_reg  <= IDLE;
            dl_reg     <= 1'b0;
            busy_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            if (accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
            state_reg <= state_next;
            dl_reg    <= downloading;
            busy_reg  <= downloading | ~empty | (state_reg != IDLE);
            ovf_reg   <= (ovf_reg & ~dl_rise) | drop;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!empty) state_next = WR;
            WR:      if (prog_rdy) state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The head entry is latched once on issue and held for the whole write.
    always_ff @(posedge clk_rom) begin
        if (rst) begin
            prog_addr <= '0;
            prog_data <= '0;
            prog_mask <= 2'b11;
            prog_we   <= 1'b0;
        end else if (issue) begin
            prog_addr <= fifo_mem[rd_ptr_reg[AW-1:0]][30:9];
            prog_data <= fifo_mem[rd_ptr_reg[AW-1:0]][7:0];
            prog_mask <= lane ? 2'b01 : 2'b10;
            prog_we   <= 1'b1;
        end else if (pop) begin
            prog_we   <= 1'b0;
        end
    end

`ifdef JTFRAME_DWNLD_CHKSUM_EN
    logic [15:0] sum_reg;

    always_ff @(posedge clk_rom) begin
        if (rst) begin
            sum_reg <= '0;
        end else begin
            sum_reg <= (dl_rise ? 16'h0000 : sum_reg) +
                       (accept ? {8'h00, ioctl_data} : 16'h0000);
        end
    end

    assign chksum = sum_reg;
`else
    assign chksum = 16'h0000;
`endif

endmodule

// File: tb/tb_jtframe_prog_pack.sv
// Self-checking bench for jtframe_prog_pack: vector table, corner-case sequences and a randomized queue model.
module tb_jtframe_prog_pack;
    localparam int DEPTH = 4;
`ifdef JTFRAME_DWNLD_CHKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk_rom = 1'b0;
    logic        rst, downloading, ioctl_wr, prog_rdy;
    logic [22:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic [21:0] prog_addr, prog_addr_s;
    logic [7:0]  prog_data, prog_data_s;
    logic [1:0]  prog_mask, prog_mask_s;
    logic        prog_we, prog_we_s, prog_rd, prog_rd_s;
    logic        dwnld_busy, dwnld_busy_s, overflow, overflow_s;
    logic [15:0] chksum, chksum_s;

    int checks = 0;
    int errors = 0;

    always #5 clk_rom = ~clk_rom;

    jtframe_prog_pack #(.DEPTH(DEPTH), .SWAB(1'b0)) dut (
        .clk_rom(clk_rom), .rst(rst), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_rdy(prog_rdy), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_mask(prog_mask), .prog_we(prog_we), .prog_rd(prog_rd),
        .dwnld_busy(dwnld_busy), .overflow(overflow), .chksum(chksum)
    );

    jtframe_prog_pack #(.DEPTH(DEPTH), .SWAB(1'b1)) dut_s (
        .clk_rom(clk_rom), .rst(rst), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_rdy(prog_rdy), .prog_addr(prog_addr_s), .prog_data(prog_data_s),
        .prog_mask(prog_mask_s), .prog_we(prog_we_s), .prog_rd(prog_rd_s),
        .dwnld_busy(dwnld_busy_s), .overflow(overflow_s), .chksum(chksum_s)
    );

    typedef struct {
        logic [22:0] addr;
        logic [7:0]  data;
        logic [21:0] exp_addr;
        logic [1:0]  exp_mask;
        logic [1:0]  exp_mask_s;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_rom);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [30:0] q[$];
        logic [30:0] h;
        logic [7:0]  got[$];
        logic        m_ovf, dl_prev, push, pop, rise;
        logic [15:0] m_sum;
        int wcnt, wdelay, pops, sent, pop_cyc, rate;
        bit done;

        vecs[0] = '{23'h000005, 8'hA5, 22'h000002, 2'b01, 2'b10};
        vecs[1] = '{23'h000000, 8'h3C, 22'h000000, 2'b10, 2'b01};
        vecs[2] = '{23'h7FFFFF, 8'hFF, 22'h3FFFFF, 2'b01, 2'b10};
        vecs[3] = '{23'h7FFFFE, 8'h00, 22'h3FFFFF, 2'b10, 2'b01};
        vecs[4] = '{23'h2AAAAB, 8'h5A, 22'h155555, 2'b01, 2'b10};
        vecs[5] = '{23'h155554, 8'h81, 22'h0AAAAA, 2'b10, 2'b01};

        rst = 1'b1; downloading = 1'b0; ioctl_wr = 1'b0; prog_rdy = 1'b0;
        ioctl_addr = '0; ioctl_data = '0;
        tick(); tick(); tick();
        chk("rst_addr", prog_addr, 0);
        chk("rst_data", prog_data, 0);
        chk("rst_mask", prog_mask, 2'b11);
        chk("rst_we", prog_we, 0);
        chk("rst_rd", prog_rd, 0);
        chk("rst_busy", dwnld_busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_chksum", chksum, 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", dwnld_busy, 0);

        // Single-byte writes from the vector table
        downloading = 1'b1;
        tick();
        foreach (vecs[i]) begin
            ioctl_addr = vecs[i].addr; ioctl_data = vecs[i].data; ioctl_wr = 1'b1;
            tick();
            ioctl_wr = 1'b0;
            chk("vec_we_early", prog_we, 0);
            tick();
            chk("vec_we", prog_we, 1);
            chk("vec_addr", prog_addr, vecs[i].exp_addr);
            chk("vec_data", prog_data, vecs[i].data);
            chk("vec_mask", prog_mask, vecs[i].exp_mask);
            chk("vec_mask_swab", prog_mask_s, vecs[i].exp_mask_s);
            tick(); tick();
            chk("vec_we_hold", prog_we, 1);
            chk("vec_addr_hold", prog_addr, vecs[i].exp_addr);
            prog_rdy = 1'b1;
            tick();
            prog_rdy = 1'b0;
            chk("vec_we_gap", prog_we, 0);
            tick();
            chk("vec_we_idle", prog_we, 0);
            $display("vec %0d: addr=%06h data=%02h -> prog_addr=%06h mask=%b mask_swab=%b",
                     i, vecs[i].addr, vecs[i].data, prog_addr, prog_mask, prog_mask_s);
        end

        // Overflow: five strobes with no prog_rdy, then a push coinciding with a pop
        downloading = 1'b0; tick();
        downloading = 1'b1; tick();
        chk("ovf_clear", overflow, 0);
        for (int k = 0; k < 5; k++) begin
            ioctl_addr = 23'h000100 + 23'(k); ioctl_data = 8'h10 + 8'(k); ioctl_wr = 1'b1;
            tick();
        end
        ioctl_wr = 1'b0;
        chk("ovf_set", overflow, 1);
        chk("ovf_first_we", prog_we, 1);
        chk("ovf_first_data", prog_data, 8'h10);
        ioctl_addr = 23'h0001FF; ioctl_data = 8'h55; ioctl_wr = 1'b1; prog_rdy = 1'b1;
        tick();
        ioctl_wr = 1'b0; prog_rdy = 1'b0;
        chk("ovf_sticky", overflow, 1);
        got.delete();
        for (int c = 0; c < 100 && got.size() < 5; c++) begin
            if (prog_we) begin
                got.push_back(prog_data);
                prog_rdy = 1'b1;
                tick();
                prog_rdy = 1'b0;
            end else begin
                tick();
            end
        end
        repeat (10) tick();
        chk("ovf_we_after", prog_we, 0);
        chk("ovf_count", got.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < got.size()) chk("ovf_data", got[k], (k == 3) ? 8'h55 : 8'h11 + 8'(k));
        end
        $display("overflow seq: %0d writes after resume, overflow=%0b", got.size(), overflow);

        // Drain: 16 bytes at 1 per 8 cycles, prog_rdy 5 cycles into each write
        wcnt = 0; pops = 0; pop_cyc = -1; done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            if (c > 0) begin
                if (pops < 16) chk("drain_busy_hi", dwnld_busy, 1);
                if (pop_cyc >= 0 && c == pop_cyc + 1) chk("drain_busy_gap", dwnld_busy, 1);
                if (pop_cyc >= 0 && c == pop_cyc + 2) begin
                    chk("drain_busy_fall", dwnld_busy, 0);
                    done = 1'b1;
                end
            end
            ioctl_wr    = (c % 8 == 0) && (c < 128);
            ioctl_addr  = 23'(c / 8); ioctl_data = 8'(c);
            downloading = (c < 121);
            if (prog_we) begin
                wcnt++;
                prog_rdy = (wcnt >= 5);
            end else begin
                wcnt = 0;
                prog_rdy = 1'b0;
            end
            if (prog_rdy) begin
                pops++;
                if (pops == 16) pop_cyc = c + 1;
            end
            if (!done) tick();
        end
        ioctl_wr = 1'b0; prog_rdy = 1'b0;
        chk("drain_done", done, 1);
        chk("drain_pops", pops, 16);
        $display("drain seq: %0d writes, busy fell at cycle %0d", pops, pop_cyc + 2);

        // Checksum over 258 bytes of 8'hFF
        tick();
        downloading = 1'b1;
        sent = 0; pops = 0;
        for (int c = 0; c < 2000 && pops < 258; c++) begin
            ioctl_wr = (c % 4 == 0) && (sent < 258);
            ioctl_data = 8'hFF; ioctl_addr = 23'(sent);
            if (ioctl_wr) sent++;
            prog_rdy = prog_we;
            if (prog_rdy) pops++;
            tick();
        end
        ioctl_wr = 1'b0; prog_rdy = 1'b0;
        repeat (3) tick();
        chk("chk_pops", pops, 258);
        chk("chk_ovf", overflow, 0);
        chk("chk_sum", chksum, CHK_EN ? 16'h00FE : 16'h0000);
        $display("checksum seq: 258 bytes, chksum=%04h", chksum);
        downloading = 1'b0; tick();
        downloading = 1'b1; tick();
        chk("chk_clear", chksum, 0);
        downloading = 1'b0;
        repeat (3) tick();

        // Randomized traffic against a queue model
        q.delete(); m_ovf = 1'b0; m_sum = '0; dl_prev = downloading;
        wcnt = 0; wdelay = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i > 0) begin
                chk("rnd_ovf", overflow, m_ovf);
                chk("rnd_sum", chksum, CHK_EN ? m_sum : 16'h0000);
                if (prog_we) begin
                    if (q.size() == 0) begin
                        chk("rnd_we_empty", prog_we, 0);
                    end else begin
                        h = q[0];
                        chk("rnd_addr", prog_addr, h[30:9]);
                        chk("rnd_data", prog_data, h[7:0]);
                        chk("rnd_mask", prog_mask, h[8] ? 2'b01 : 2'b10);
                        chk("rnd_mask_swab", prog_mask_s, h[8] ? 2'b10 : 2'b01);
                    end
                end
            end
            rate = (i < 300) ? 70 : (i < 600) ? 20 : (i < 900) ? 90 : 40;
            downloading = (i < 1400);
            ioctl_wr    = downloading && ($urandom_range(0, 99) < rate);
            ioctl_addr  = 23'($urandom);
            ioctl_data  = 8'($urandom);
            if (prog_we) begin
                prog_rdy = (wcnt >= wdelay);
                wcnt++;
            end else begin
                wcnt = 0;
                prog_rdy = ($urandom_range(0, 19) == 0);
            end
            pop  = prog_we && prog_rdy;
            push = ioctl_wr && downloading;
            rise = downloading && !dl_prev;
            if (rise) begin
                m_ovf = 1'b0;
                m_sum = '0;
            end
            if (push) begin
                if (q.size() < DEPTH || pop) begin
                    q.push_back({ioctl_addr, ioctl_data});
                    m_sum = m_sum + 16'(ioctl_data);
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (pop) begin
                void'(q.pop_front());
                wdelay = $urandom_range(0, 5);
            end
            dl_prev = downloading;
            tick();
        end
        ioctl_wr = 1'b0; prog_rdy = 1'b0;
        chk("rnd_drained", q.size(), 0);
        chk("rnd_busy_end", dwnld_busy, 0);
        $display("random seq: 1500 cycles, final overflow=%0b chksum=%04h", overflow, chksum);

        // Reset while a write is pending
        downloading = 1'b1;
        ioctl_addr = 23'h000042; ioctl_data = 8'h77; ioctl_wr = 1'b1; tick();
        ioctl_addr = 23'h000043; ioctl_data = 8'h78; tick();
        ioctl_wr = 1'b0;
        for (int c = 0; c < 10 && !prog_we; c++) tick();
        chk("rstwr_we_before", prog_we, 1);
        rst = 1'b1; downloading = 1'b0;
        tick();
        chk("rstwr_we", prog_we, 0);
        chk("rstwr_busy", dwnld_busy, 0);
        chk("rstwr_mask", prog_mask, 2'b11);
        rst = 1'b0; prog_rdy = 1'b1;
        tick();
        prog_rdy = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk("rstwr_no_we", prog_we, 0);
            chk("rstwr_empty", dwnld_busy, 0);
            tick();
        end
        $display("reset mid-write seq: prog_we=%0b busy=%0b", prog_we, dwnld_busy);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/jtframe_prog_pack.md
# jtframe_prog_pack

Download packer between the HPS byte stream and the SDRAM programming port of `jtframe_mister`. It receives `ioctl_*` bytes while a ROM is being downloaded and turns each byte into one SDRAM programming write: word address, byte-lane mask and data. A small FIFO absorbs bursts from the HPS while the SDRAM controller completes writes. It also generates `dwnld_busy`, which holds the game in reset until the last byte has been written to SDRAM.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; must be a power of 2, minimum 2.
- `SWAB`, 0: when 1, swaps the byte lanes, so an even `ioctl_addr` writes the high byte.

Ports:
- `clk_rom`  in  1: single clock for the whole block.
- `rst`  in  1: synchronous, active-high reset.
- `downloading`  in  1: download window from `hps_io`.
- `ioctl_addr`  in  23: byte address of the incoming byte.
- `ioctl_data`  in  8: incoming byte.
- `ioctl_wr`  in  1: single-cycle byte strobe.
- `prog_rdy`  in  1: single-cycle pulse from the SDRAM controller when the current write has completed.
- `prog_addr`  out  22: word address; equals `ioctl_addr[22:1]` of the entry.
- `prog_data`  out  8: data byte; the SDRAM controller replicates it on both lanes.
- `prog_mask`  out  2: active-low lane mask. 2'b10 writes the low byte, 2'b01 writes the high byte.
- `prog_we`  out  1: write request, held until `prog_rdy`.
- `prog_rd`  out  1: tied to 0.
- `dwnld_busy`  out  1: high while a download or any pending write is in progress.
- `overflow`  out  1: sticky flag; set when a byte was dropped.
- `chksum`  out  16: additive checksum of accepted bytes (see Configuration).

## Operation
- Accept condition: `ioctl_wr & downloading`. Strobes outside the download window are ignored.
- FIFO entry contents: {`ioctl_addr[22:0]`, `ioctl_data`}.
- Full FIFO, push only: the byte is dropped and `overflow` is set to 1.
- Full FIFO, simultaneous push and pop: the push is accepted and `overflow` is unchanged.
- Rising edge of `downloading` clears `overflow` and `chksum`. FIFO pointers are not touched.
- Mask computation: lane bit `b = ioctl_addr[0] ^ SWAB`. If `b` = 0, `prog_mask` = 2'b10; if `b` = 1, `prog_mask` = 2'b01.
- Issue FSM states: IDLE, WR, GAP.
  - IDLE: if the FIFO is not empty, register the head entry onto `prog_addr`/`prog_data`/`prog_mask`, set `prog_we`=1 and go to WR.
  - WR: hold all `prog_*` outputs stable. On `prog_rdy`, pop the head, set `prog_we`=0 and go to GAP.
  - GAP: one cycle with `prog_we` low, so the controller sees a fresh rising edge. Then go to IDLE.
- `prog_rdy` outside WR is ignored.
- `dwnld_busy` = `downloading` | FIFO not empty | state != IDLE. The output is registered.

## Timing
- Reset values:
  - `prog_addr`=0, `prog_data`=0, `prog_mask`=2'b11, `prog_we`=0, `prog_rd`=0.
  - `dwnld_busy`=0, `overflow`=0, `chksum`=0.
  - FIFO empty, state IDLE.
- Reset mid-write: the FIFO is flushed and `prog_we` is low in the cycle after `rst` is sampled. The pending `prog_rdy` is ignored.
- Latency: byte strobe sampled at edge n → entry in FIFO after n → `prog_we` high after edge n+1, when the FIFO was empty and the FSM was in IDLE.
- Back-to-back writes: minimum spacing between `prog_we` rising edges is 3 cycles (WR with immediate `prog_rdy`, then GAP, then IDLE).
- Sustained throughput: one byte per 3 cycles at best. The HPS rate (about 1 byte per 8+ cycles) never overflows a working controller.
- Drain: `dwnld_busy` falls one cycle after the FSM reaches IDLE with an empty FIFO and `downloading` low.
- Pointer width: log2(DEPTH)+1 bits, so full and empty are distinguished by the extra wrap bit.

## Configuration
- `JTFRAME_DWNLD_CHKSUM_EN` defined:
  - `chksum` accumulates the sum of accepted bytes, 16 bits, wrapping mod 2^16, at push time.
  - Dropped bytes are excluded.
  - Cleared on reset and on the rising edge of `downloading`.
- Not defined: `chksum` is tied to 16'h0000 and no adder is synthesised.

## Test plan
- Single byte: `downloading`=1, `ioctl_addr`=23'h000005, data 8'hA5 → `prog_we` high 2 cycles later, `prog_addr`=22'h000002, `prog_mask`=2'b01, `prog_data`=8'hA5. Held until `prog_rdy`, then low for at least 1 cycle.
- Byte swap: repeat the single-byte case with SWAB=1 → `prog_mask`=2'b10.
- Overflow: DEPTH=4, `prog_rdy` held low, 5 strobes → `overflow`=1 and 4 writes issued once `prog_rdy` resumes. A 5th strobe in the same cycle as a pop is accepted.
- Drain and busy: 16 bytes at 1 per 8 cycles, `prog_rdy` 5 cycles after each `prog_we`, `downloading` falls after the last byte → `dwnld_busy` stays high until the final write completes, then falls 1 cycle after IDLE.
- Checksum (macro defined): bytes 8'hFF ×258 → `chksum`=16'h00FE. A new download clears it to 0.
- Reset mid-WR: assert `rst` during WR → next cycle `prog_we`=0, FIFO empty, `dwnld_busy`=0. A late `prog_rdy` causes no write.
